tlb_entry_file: RTL and testbench
=================================

// Module: tlb_entry_file
// PURPOSE
//  Holds the TLB entry array and drives it onto the `entries` bus read by the
//  combinational lookup networks (instruction and data).
//  Executes CP0 TLB instructions TLBWI, TLBWR, TLBR and TLBP through a valid/ready
//  handshake and reports completion with a one-cycle done pulse.
//  Maintains the CP0 Random register, bounded below by Wired.
// PARAMETERS
//  ENTRIES      TLB_ENTRIES_NUM (16)   number of entries; index width IDX_W = $clog2(ENTRIES)
//  RANDOM_TOP   ENTRIES-1              Random value after reset and after any Wired write
// PORTS
//  clk          in   1              single clock, all state on rising edge
//  resetn       in   1              asynchronous, active-low reset
//  op_valid     in   1              TLB instruction request
//  op           in   2              00 TLBWI, 01 TLBWR, 10 TLBP, 11 TLBR
//  op_ready     out  1              request accepted when op_valid && op_ready
//  op_index     in   IDX_W          CP0 Index.idx for TLBWI/TLBR
//  wr_entry     in   tlb_entry_t    EntryHi/EntryLo0/EntryLo1/PageMask image; key for TLBP
//  wired        in   IDX_W          CP0 Wired value
//  wired_we     in   1              CP0 write to Wired this cycle
//  entries      out  tlb_entry_t[ENTRIES]  registered entry array to lookup stages
//  random       out  IDX_W          CP0 Random register
//  done         out  1              one-cycle completion pulse
//  rd_entry     out  tlb_entry_t    TLBR result; valid when done for TLBR
//  probe_index  out  tlb_index_t    TLBP result {p, idx}; valid when done for TLBP
// BEHAVIOUR
//  Reset: all entries zero (both transec.v = 0); random = RANDOM_TOP; state IDLE;
//   op_ready = 1; done = 0; rd_entry = 0; probe_index = {p=1, idx=0}.
//  FSM states: IDLE, PROBE, DONE. op_ready = (state == IDLE).
//  IDLE, accepted TLBWI: entries[op_index] <= wr_entry -> DONE.
//  IDLE, accepted TLBWR: entries[random] <= wr_entry, using the pre-edge random -> DONE.
//  IDLE, accepted TLBR: rd_entry <= entries[op_index] -> DONE.
//  IDLE, accepted TLBP: wr_entry.compsec is latched as the probe key -> PROBE.
//  PROBE: compares the key against all entries.
//   Hit condition: (vpn2 & ~{ones, pagemask_i}) equal on both sides, and (g_i || asid_i == key asid).
//   Pagemask comes from the stored entry.
//   Multiple hits: the highest index wins, matching the lookup network.
//   probe_index <= hit ? {0, idx} : {1, 0} -> DONE.
//  DONE: done = 1 for exactly this cycle -> IDLE.
//   Latency from accept to done: TLBWI/TLBWR/TLBR 1 cycle, TLBP 2 cycles.
//  op_index >= ENTRIES (non-power-of-2 ENTRIES):
//   TLBWI writes nothing; TLBR returns 0; done still pulses.
//  Entry writes become visible on `entries` the cycle after the accept edge.
//   No bypass to lookups in the same cycle.
//  TLBP sees any write accepted before it.
//   Back-to-back TLBWI then TLBP on the same entry: the probe sees the new entry.
//  Random:
//   - Decrements every cycle.
//   - When random == wired or random == 0, next value is RANDOM_TOP.
//   - wired >= RANDOM_TOP holds random at RANDOM_TOP.
//   - wired_we: random <= RANDOM_TOP, with priority over decrement.
//   - A TLBWR in the same cycle as wired_we uses the old random.
//  Random never holds a value < wired outside the cycle after a Wired write.
//  op_valid outside IDLE is ignored (not queued); the requester holds op_valid until accepted.
//  resetn low mid-operation (PROBE/DONE): immediately IDLE, no done.
//   An interrupted write is either fully applied (edge passed) or absent.
// TESTING
//  - Reset, then TLBR idx 3 -> done 1 cycle after accept; rd_entry all zero; random == ENTRIES-1.
//  - TLBWI idx 5 {vpn2=0x12345, asid=7, g=0, pagemask=0}, then TLBP with the same key
//    -> done 2 cycles after accept; probe_index = {0,5}. Same with asid=8 -> {1,0}.
//  - Write idx 2 with g=1, pagemask=16'h0003, vpn2=0x00100; probe vpn2=0x00101, asid=9
//    -> {0,2}. Same entry in idx 2 and idx 9 -> {0,9}.
//  - wired=4, wired_we, then 40 idle cycles -> random sequence 15,14..4,15,14..; never below 4.
//    TLBWR in the wired_we cycle writes the old random index.
//  - TLBWI idx 7, then a lookup of that address the next cycle -> entries[7] updated.
//    op_valid held during PROBE -> not accepted until IDLE; exactly one done per op.
//  - Assert resetn in PROBE -> done stays 0; entries cleared; op_ready = 1 after release.

Source files
------------

// File: rtl/tlb_entry_file_pkg.sv
// Shared types for the TLB entry file: entry image, probe index and op encodings.
package tlb_entry_file_pkg;

   localparam int unsigned TLB_ENTRIES_NUM = 16;
   localparam int unsigned TLB_IDX_W       = $clog2(TLB_ENTRIES_NUM);
   localparam int unsigned VPN2_W          = 19;
   localparam int unsigned ASID_W          = 8;
   localparam int unsigned MASK_W          = 16;
   localparam int unsigned PFN_W           = 20;

   localparam logic [1:0] OP_TLBWI = 2'b00;
   localparam logic [1:0] OP_TLBWR = 2'b01;
   localparam logic [1:0] OP_TLBP  = 2'b10;
   localparam logic [1:0] OP_TLBR  = 2'b11;

   typedef struct packed {
      logic [VPN2_W-1:0] vpn2;
      logic [ASID_W-1:0] asid;
      logic              g;
      logic [MASK_W-1:0] pagemask;
   } tlb_compsec_t;

   typedef struct packed {
      logic [PFN_W-1:0] pfn;
      logic [2:0]       c;
      logic             d;
      logic             v;
   } tlb_transec_t;

   typedef struct packed {
      tlb_compsec_t       compsec;
      tlb_transec_t [1:0] transec;
   } tlb_entry_t;

   typedef struct packed {
      logic                 p;
      logic [TLB_IDX_W-1:0] idx;
   } tlb_index_t;

endpackage

// File: rtl/tlb_entry_file.sv
// TLB entry array with CP0 TLBWI/TLBWR/TLBR/TLBP execution and the Random register.
// Entries are registered; writes reach the lookup networks the cycle after accept.
module tlb_entry_file
   import tlb_entry_file_pkg::*;
#(
   parameter  int unsigned ENTRIES = TLB_ENTRIES_NUM,
   localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             op_valid,
   input  logic [1:0]       op,
   output logic             op_ready,
   input  logic [IDX_W-1:0] op_index,
   input  tlb_entry_t       wr_entry,
   input  logic [IDX_W-1:0] wired,
   input  logic             wired_we,
   output tlb_entry_t       entries [ENTRIES],
   output logic [IDX_W-1:0] random,
   output logic             done,
   output tlb_entry_t       rd_entry,
   output tlb_index_t       probe_index
);

   localparam logic [IDX_W-1:0] RANDOM_TOP = IDX_W'(ENTRIES - 1);

   typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

   state_t              state, state_next;
   logic                do_wi, do_wr, do_rd, do_key, do_probe;
   logic                idx_ok;
   logic [VPN2_W-1:0]   key_vpn2;
   logic [ASID_W-1:0]   key_asid;
   logic                hit;
   logic [TLB_IDX_W-1:0] hit_idx;
   logic [VPN2_W-1:0]   vmask;
   logic [IDX_W-1:0]    random_next;

   // Indices past the array (non-power-of-2 ENTRIES) neither write nor read.
   assign idx_ok = 32'(op_index) < ENTRIES;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      do_wi      = 1'b0;
      do_wr      = 1'b0;
      do_rd      = 1'b0;
      do_key     = 1'b0;
      do_probe   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (op_valid) begin
               unique case (op)
                  OP_TLBWI: begin do_wi  = 1'b1; state_next = S_DONE;  end
                  OP_TLBWR: begin do_wr  = 1'b1; state_next = S_DONE;  end
                  OP_TLBR:  begin do_rd  = 1'b1; state_next = S_DONE;  end
                  OP_TLBP:  begin do_key = 1'b1; state_next = S_PROBE; end
                  default:  state_next = S_IDLE;
               endcase
            end
         end
         S_PROBE: begin
            do_probe   = 1'b1;
            state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Random wraps to the top at Wired (or zero) and is pinned there when Wired covers it.
   always_comb begin
      random_next = random - IDX_W'(1);
      if (wired_we || (wired >= RANDOM_TOP) || (random <= wired) || (random == '0))
         random_next = RANDOM_TOP;
   end

   // Probe compare against the stored array; later indices override earlier hits.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      vmask   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         vmask = ~{{(VPN2_W - MASK_W){1'b1}}, entries[i].compsec.pagemask};
         if ((((entries[i].compsec.vpn2 ^ key_vpn2) & vmask) == '0) &&
             (entries[i].compsec.g || (entries[i].compsec.asid == key_asid))) begin
            hit     = 1'b1;
            hit_idx = TLB_IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
         random      <= RANDOM_TOP;
         done        <= 1'b0;
         op_ready    <= 1'b1;
         rd_entry    <= '0;
         probe_index <= {1'b1, TLB_IDX_W'(0)};
         key_vpn2    <= '0;
         key_asid    <= '0;
      end else begin
         random   <= random_next;
         done     <= (state_next == S_DONE);
         op_ready <= (state_next == S_IDLE);
         if (do_wi && idx_ok) entries[op_index] <= wr_entry;
         if (do_wr)           entries[random]   <= wr_entry;
         if (do_rd)           rd_entry <= idx_ok ? entries[op_index] : '0;
         if (do_key) begin
            key_vpn2 <= wr_entry.compsec.vpn2;
            key_asid <= wr_entry.compsec.asid;
         end
         if (do_probe) probe_index <= hit ? {1'b0, hit_idx} : {1'b1, TLB_IDX_W'(0)};
      end
   end

endmodule

// File: tb/tb_tlb_entry_file.sv
// Self-checking bench for tlb_entry_file: scoreboarded TLB ops plus scripted timing scenarios.
module tb_tlb_entry_file;
   import tlb_entry_file_pkg::*;

   localparam int unsigned N  = TLB_ENTRIES_NUM;
   localparam int unsigned IW = TLB_IDX_W;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          op_valid = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [IW-1:0] op_index = '0;
   tlb_entry_t    wr_entry = '0;
   logic [IW-1:0] wired = '0;
   logic          wired_we = 1'b0;
   tlb_entry_t    entries [N];
   logic [IW-1:0] random;
   logic          done;
   logic          op_ready;
   tlb_entry_t    rd_entry;
   tlb_index_t    probe_index;

   tlb_entry_file dut (
      .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op), .op_ready(op_ready),
      .op_index(op_index), .wr_entry(wr_entry), .wired(wired), .wired_we(wired_we),
      .entries(entries), .random(random), .done(done), .rd_entry(rd_entry),
      .probe_index(probe_index)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int done_cnt = 0;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   typedef struct {
      logic [1:0] op;
      int         lat;
      logic       chk_rd;
      tlb_entry_t rd;
      logic       chk_pi;
      tlb_index_t pi;
   } exp_t;
   typedef struct {
      int         lat;
      tlb_entry_t rd;
      tlb_index_t pi;
   } obs_t;

   exp_t       exp_q [$];
   obs_t       obs_q [$];
   tlb_entry_t model [N];

   function automatic tlb_entry_t mk(input logic [18:0] v, input logic [7:0] a, input logic g,
                                     input logic [15:0] pm, input logic [19:0] pfn);
      tlb_entry_t e;
      e.compsec.vpn2     = v;
      e.compsec.asid     = a;
      e.compsec.g        = g;
      e.compsec.pagemask = pm;
      e.transec[1]       = '{pfn: pfn, c: 3'd3, d: 1'b1, v: 1'b1};
      e.transec[0]       = '{pfn: pfn + 20'd1, c: 3'd2, d: 1'b0, v: 1'b1};
      return e;
   endfunction

   function automatic tlb_index_t pidx(input logic p, input int i);
      tlb_index_t r;
      r.p   = p;
      r.idx = IW'(i);
      return r;
   endfunction

   function automatic void clear_model();
      for (int i = 0; i < N; i++) model[i] = '0;
   endfunction

   function automatic int count_diff();
      int bad = 0;
      for (int i = 0; i < N; i++) if (entries[i] !== model[i]) bad++;
      return bad;
   endfunction

   // Drive one op, wait for acceptance and done; record latency and result outputs.
   task automatic do_op(input logic [1:0] o, input int idx, input tlb_entry_t e);
      obs_t ob;
      int   n;
      ob.lat = -1; ob.rd = '0; ob.pi = '0;
      @(negedge clk);
      op_valid = 1'b1; op = o; op_index = IW'(idx); wr_entry = e;
      n = 0;
      while (op_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (op_ready === 1'b1) begin
         @(posedge clk);
         #1 op_valid = 1'b0;
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin ob.lat = c; break; end
         end
         ob.rd = rd_entry;
         ob.pi = probe_index;
      end else op_valid = 1'b0;
      obs_q.push_back(ob);
   endtask

   task automatic issue(input logic [1:0] o, input int idx, input tlb_entry_t e, input int lat,
                        input tlb_index_t pi);
      exp_t ex;
      ex.op = o; ex.lat = lat;
      ex.chk_rd = (o == OP_TLBR); ex.rd = model[idx];
      ex.chk_pi = (o == OP_TLBP); ex.pi = pi;
      exp_q.push_back(ex);
      if (o == OP_TLBWI) model[idx] = e;
      do_op(o, idx, e);
   endtask

   task automatic test_reset();
      exp_t ex; obs_t ob;
      resetn = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      tests_run++; if (op_ready !== 1'b1 || done !== 1'b0) begin tests_failed++;
         $display("FAIL reset_hs: got ready=%b done=%b want ready=1 done=0", op_ready, done); end
      tests_run++; if (random !== IW'(N - 1)) begin tests_failed++;
         $display("FAIL reset_random: got %0d want %0d", random, N - 1); end
      tests_run++; if (probe_index !== pidx(1'b1, 0) || rd_entry !== '0) begin tests_failed++;
         $display("FAIL reset_outs: got pi=%h rd=%h want pi=%h rd=0", probe_index, rd_entry, pidx(1'b1, 0)); end
      tests_run++; if (count_diff() != 0) begin tests_failed++;
         $display("FAIL reset_entries: got %0d nonzero entries want 0", count_diff()); end
      resetn = 1'b1;
      issue(OP_TLBR, 3, '0, 1, '0);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         ex = exp_q.pop_front(); ob = obs_q.pop_front();
         tests_run++; if (ob.lat !== ex.lat) begin tests_failed++;
            $display("FAIL reset_tlbr_latency: got %0d want %0d", ob.lat, ex.lat); end
         tests_run++; if (ob.rd !== ex.rd) begin tests_failed++;
            $display("FAIL reset_tlbr_rd: got %h want %h", ob.rd, ex.rd); end
      end
   endtask

   task automatic test_probe_asid();
      exp_t ex; obs_t ob;
      tlb_entry_t e1 = mk(19'h12345, 8'd7, 1'b0, 16'h0000, 20'hABCDE);
      tlb_entry_t k8 = mk(19'h12345, 8'd8, 1'b0, 16'h0000, 20'h0);
      issue(OP_TLBWI, 5, e1, 1, '0);
      issue(OP_TLBP,  0, e1, 2, pidx(1'b0, 5));
      issue(OP_TLBP,  0, k8, 2, pidx(1'b1, 0));
      issue(OP_TLBR,  5, '0, 1, '0);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         ex = exp_q.pop_front(); ob = obs_q.pop_front();
         tests_run++; if (ob.lat !== ex.lat) begin tests_failed++;
            $display("FAIL asid_latency op=%0d: got %0d want %0d", ex.op, ob.lat, ex.lat); end
         if (ex.chk_rd) begin tests_run++; if (ob.rd !== ex.rd) begin tests_failed++;
            $display("FAIL asid_tlbr_rd: got %h want %h", ob.rd, ex.rd); end end
         if (ex.chk_pi) begin tests_run++; if (ob.pi !== ex.pi) begin tests_failed++;
            $display("FAIL asid_probe: got %h want %h", ob.pi, ex.pi); end end
      end
   endtask

   task automatic test_probe_mask_global();
      exp_t ex; obs_t ob;
      tlb_entry_t e2 = mk(19'h00100, 8'd1, 1'b1, 16'h0003, 20'h00200);
      tlb_entry_t ka = mk(19'h00101, 8'd9, 1'b0, 16'h0000, 20'h0);
      tlb_entry_t kb = mk(19'h00104, 8'd9, 1'b0, 16'h0000, 20'h0);
      issue(OP_TLBWI, 2, e2, 1, '0);
      issue(OP_TLBP,  0, ka, 2, pidx(1'b0, 2));
      issue(OP_TLBP,  0, kb, 2, pidx(1'b1, 0));
      issue(OP_TLBWI, 9, e2, 1, '0);
      issue(OP_TLBP,  0, ka, 2, pidx(1'b0, 9));
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         ex = exp_q.pop_front(); ob = obs_q.pop_front();
         tests_run++; if (ob.lat !== ex.lat) begin tests_failed++;
            $display("FAIL mask_latency op=%0d: got %0d want %0d", ex.op, ob.lat, ex.lat); end
         if (ex.chk_pi) begin tests_run++; if (ob.pi !== ex.pi) begin tests_failed++;
            $display("FAIL mask_probe: got %h want %h", ob.pi, ex.pi); end end
      end
   endtask

   // WI -> TLBP -> TLBR with op_valid held throughout; only IDLE may accept.
   task automatic test_back_to_back();
      tlb_entry_t e3 = mk(19'h07777, 8'd3, 1'b0, 16'h0000, 20'h00777);
      int d0;
      @(posedge clk); #1 d0 = done_cnt;
      @(negedge clk);
      op_valid = 1'b1; op = OP_TLBWI; op_index = IW'(7); wr_entry = e3;
      tests_run++; if (entries[7] !== model[7]) begin tests_failed++;
         $display("FAIL b2b_no_bypass: got %h want %h", entries[7], model[7]); end
      model[7] = e3;
      @(posedge clk); #1 op = OP_TLBP;
      @(negedge clk);
      tests_run++; if (entries[7] !== e3 || done !== 1'b1) begin tests_failed++;
         $display("FAIL b2b_wi_visible: got e=%h done=%b want e=%h done=1", entries[7], done, e3); end
      @(negedge clk);
      tests_run++; if (op_ready !== 1'b1 || done !== 1'b0) begin tests_failed++;
         $display("FAIL b2b_idle: got ready=%b done=%b want 1 0", op_ready, done); end
      @(posedge clk); #1 op = OP_TLBR;
      @(negedge clk);
      tests_run++; if (op_ready !== 1'b0 || done !== 1'b0) begin tests_failed++;
         $display("FAIL b2b_probe_busy: got ready=%b done=%b want 0 0", op_ready, done); end
      @(negedge clk);
      tests_run++; if (done !== 1'b1 || probe_index !== pidx(1'b0, 7) || op_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_probe: got done=%b pi=%h ready=%b want 1 %h 0", done, probe_index, op_ready, pidx(1'b0, 7)); end
      @(negedge clk);
      tests_run++; if (op_ready !== 1'b1 || done !== 1'b0) begin tests_failed++;
         $display("FAIL b2b_idle2: got ready=%b done=%b want 1 0", op_ready, done); end
      @(posedge clk); #1 op_valid = 1'b0;
      @(negedge clk);
      tests_run++; if (done !== 1'b1 || rd_entry !== e3) begin tests_failed++;
         $display("FAIL b2b_tlbr: got done=%b rd=%h want 1 %h", done, rd_entry, e3); end
      @(posedge clk); #1;
      tests_run++; if (done_cnt - d0 != 3) begin tests_failed++;
         $display("FAIL b2b_done_count: got %0d want 3", done_cnt - d0); end
   endtask

   task automatic test_random();
      tlb_entry_t e4 = mk(19'h04444, 8'd4, 1'b0, 16'h0000, 20'h00444);
      int exp_r;
      int bad;
      @(negedge clk); resetn = 1'b0;
      @(negedge clk); resetn = 1'b1; clear_model();
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         tests_run++; if (random !== IW'(N - 1 - k)) begin tests_failed++;
            $display("FAIL random_decr k=%0d: got %0d want %0d", k, random, N - 1 - k); end
      end
      op_valid = 1'b1; op = OP_TLBWR; wr_entry = e4; wired = IW'(4); wired_we = 1'b1;
      model[12] = e4;
      @(posedge clk); #1 op_valid = 1'b0; wired_we = 1'b0;
      exp_r = N - 1; bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (random !== IW'(exp_r) || random < IW'(4)) bad++;
         exp_r = (exp_r == 4) ? N - 1 : exp_r - 1;
      end
      tests_run++; if (bad != 0) begin tests_failed++;
         $display("FAIL random_wired4: got %0d bad cycles want 0", bad); end
      tests_run++; if (count_diff() != 0) begin tests_failed++;
         $display("FAIL tlbwr_old_random: got e12=%h e15=%h want e12=%h e15=0", entries[12], entries[15], e4); end
      @(negedge clk); wired = IW'(N - 1); wired_we = 1'b1;
      @(posedge clk); #1 wired_we = 1'b0;
      bad = 0;
      repeat (5) begin @(negedge clk); if (random !== IW'(N - 1)) bad++; end
      tests_run++; if (bad != 0) begin tests_failed++;
         $display("FAIL random_hold_top: got %0d bad cycles want 0", bad); end
      @(negedge clk); wired = '0; wired_we = 1'b1;
      @(posedge clk); #1 wired_we = 1'b0;
      exp_r = N - 1; bad = 0;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         if (random !== IW'(exp_r)) bad++;
         exp_r = (exp_r == 0) ? N - 1 : exp_r - 1;
      end
      tests_run++; if (bad != 0) begin tests_failed++;
         $display("FAIL random_wrap_zero: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_reset_mid();
      exp_t ex; obs_t ob;
      tlb_entry_t e5 = mk(19'h05555, 8'd5, 1'b0, 16'h0000, 20'h00555);
      int d0;
      issue(OP_TLBWI, 1, e5, 1, '0);
      ex = exp_q.pop_front(); ob = obs_q.pop_front();
      tests_run++; if (ob.lat !== ex.lat) begin tests_failed++;
         $display("FAIL mid_wi_latency: got %0d want %0d", ob.lat, ex.lat); end
      @(negedge clk); op_valid = 1'b1; op = OP_TLBP; wr_entry = e5;
      @(posedge clk); #1 op_valid = 1'b0; d0 = done_cnt;
      @(negedge clk); resetn = 1'b0; clear_model();
      #1;
      tests_run++; if (done !== 1'b0 || op_ready !== 1'b1 || probe_index !== pidx(1'b1, 0)) begin
         tests_failed++;
         $display("FAIL mid_reset_outs: got done=%b ready=%b pi=%h want 0 1 %h", done, op_ready, probe_index, pidx(1'b1, 0)); end
      tests_run++; if (count_diff() != 0) begin tests_failed++;
         $display("FAIL mid_reset_entries: got %0d nonzero want 0", count_diff()); end
      @(negedge clk); resetn = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      tests_run++; if (done_cnt != d0 || op_ready !== 1'b1) begin tests_failed++;
         $display("FAIL mid_no_done: got dones=%0d ready=%b want 0 1", done_cnt - d0, op_ready); end
      issue(OP_TLBR, 1, '0, 1, '0);
      ex = exp_q.pop_front(); ob = obs_q.pop_front();
      tests_run++; if (ob.lat !== ex.lat || ob.rd !== ex.rd) begin tests_failed++;
         $display("FAIL mid_tlbr: got lat=%0d rd=%h want %0d %h", ob.lat, ob.rd, ex.lat, ex.rd); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_probe_asid();
      test_probe_mask_global();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
